// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
// Shared definitions for the AHB-lite bridge arbiter: HTRANS/HRESP codes,
// the grant FSM state type and the round-robin winner function used by
// rr_picker. The function works on a fixed 8-bit request vector so it can
// serve any arbiter width from 2 to 8 masters.
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam int MAX_MST   = 8;
   localparam int MAX_MST_W = 3;

   typedef enum logic [1:0] {
      IDLE,      // nobody owns the address phase
      GRANT,     // granted master drives the bridge
      HANDOVER   // one IDLE cycle between two owners
   } arb_state_e;

   // First set bit of req at or after ptr, wrapping at n; one-hot result.
   function automatic logic [MAX_MST-1:0] rr_pick(input logic [MAX_MST-1:0]   req,
                                                  input logic [MAX_MST_W-1:0] ptr,
                                                  input int                   n);
      logic [MAX_MST-1:0]   win;
      logic                 found;
      logic [MAX_MST_W-1:0] idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_MST; k++) begin
         idx = MAX_MST_W'((int'(ptr) + k) % n);
         if ((k < n) && !found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotate-priority encoder: picks the first requester at or
// after ptr_i.
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
// ---------------------------------------------------------------------------
module rr_picker
   import ahb_arb_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   assign grant_o = N'(rr_pick(MAX_MST'(req_i), MAX_MST_W'(ptr_i), N));
   assign valid_o = |req_i;

   // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_o[i]) idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bridge_arbiter
// Round-robin AHB-lite arbiter sharing the bridge's single slave port among
// NUM_MST masters. Tracks address-phase owner (grant) and data-phase owner,
// muxes address/control/write data to the bridge and routes Hreadyout back.
// Hreadyin is only raised for real NONSEQ/SEQ transfers of the granted master.
//   clk, rst            : clock, asynchronous active-low reset
//   m_req/m_haddr/...   : per-master request and AHB address/control/data
//   m_hgrant, m_hready  : per-master grant and ready
//   m_hrdata, m_hresp   : bridge read data / response, broadcast
//   Haddr..Hreadyin     : to the bridge; Hreadyout/Hrdata/Hresp from it
// Optional: define AHB_ARB_LOCK_EN to let a granted master hold the bus with
// m_hlock, suppressing the MAX_HOLD rotation.
// ---------------------------------------------------------------------------
module ahb_bridge_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MST  = 3,
   parameter int MAX_HOLD = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MST-1:0]        m_req,
   input  logic [NUM_MST*ADDR_W-1:0] m_haddr,
   input  logic [NUM_MST*2-1:0]      m_htrans,
   input  logic [NUM_MST-1:0]        m_hwrite,
   input  logic [NUM_MST*DATA_W-1:0] m_hwdata,
   input  logic [NUM_MST-1:0]        m_hlock,
   output logic [NUM_MST-1:0]        m_hgrant,
   output logic [NUM_MST-1:0]        m_hready,
   output logic [DATA_W-1:0]         m_hrdata,
   output logic [1:0]                m_hresp,
   output logic [ADDR_W-1:0]         Haddr,
   output logic [1:0]                Htrans,
   output logic                      Hwrite,
   output logic [DATA_W-1:0]         Hwdata,
   output logic                      Hreadyin,
   input  logic                      Hreadyout,
   input  logic [DATA_W-1:0]         Hrdata,
   input  logic [1:0]                Hresp
);

   localparam int                IDX_W    = $clog2(NUM_MST);
   localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MST - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   arb_state_e         state_q, state_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               down_q, down_d;   // data phase outstanding
   logic [IDX_W-1:0]   didx_q, didx_d;   // data-phase owner

   logic [1:0]         g_htrans;
   logic [ADDR_W-1:0]  g_haddr;
   logic               g_hwrite, g_req, g_lock;
   logic               others_req, splittable, rule_a, rule_b, accept;
   logic [1:0]         bus_htrans;
   logic [IDX_W-1:0]   next_ptr, pick_ptr, pick_idx;
   logic [NUM_MST-1:0] pick_req, pick_grant;
   logic               pick_valid;

   // Signals of the currently granted master (all zero when none).
   always_comb begin
      g_htrans = HTRANS_IDLE;
      g_haddr  = '0;
      g_hwrite = 1'b0;
      g_req    = 1'b0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_q[i]) begin
            g_htrans = m_htrans[i*2 +: 2];
            g_haddr  = m_haddr[i*ADDR_W +: ADDR_W];
            g_hwrite = m_hwrite[i];
            g_req    = m_req[i];
         end
      end
   end

`ifdef AHB_ARB_LOCK_EN
   assign g_lock = |(m_hlock & grant_q);
`else
   logic unused_hlock;
   assign unused_hlock = ^m_hlock;
   assign g_lock       = 1'b0;
`endif

   assign others_req = |(m_req & ~grant_q);
   // Never rotate inside a burst: only at IDLE or a fresh NONSEQ.
   assign splittable = (g_htrans != HTRANS_SEQ) && (g_htrans != HTRANS_BUSY);
   assign rule_a     = (state_q == GRANT) && !g_req && (g_htrans == HTRANS_IDLE);
   assign rule_b     = (state_q == GRANT) && (hold_q == HOLD_MAX) && others_req
                       && splittable && !g_lock;
   // While a forced rotation is pending, the master's next transfer is held
   // off so the hold limit is exact.
   assign bus_htrans = ((state_q == GRANT) && !rule_b) ? g_htrans : HTRANS_IDLE;
   assign accept     = Hreadyout && (state_q == GRANT)
                       && ((bus_htrans == HTRANS_NONSEQ) || (bus_htrans == HTRANS_SEQ));

   assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
   assign pick_req = (state_q == IDLE) ? m_req : (m_req & ~grant_q);
   assign pick_ptr = (state_q == IDLE) ? ptr_q : next_ptr;

   rr_picker #(.N(NUM_MST), .IDX_W(IDX_W)) u_picker (
      .req_i   (pick_req),
      .ptr_i   (pick_ptr),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         down_q  <= 1'b0;
         didx_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         down_q  <= down_d;
         didx_q  <= didx_d;
      end
   end

   // Next state; a bridge wait state (Hreadyout=0) freezes everything.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      down_d  = down_q;
      didx_d  = didx_q;
      if (Hreadyout) begin
         if (accept) begin
            down_d = 1'b1;
            didx_d = gidx_q;
            if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
         end else begin
            down_d = 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_d = pick_grant;
                  gidx_d  = pick_idx;
                  state_d = GRANT;
               end
            end
            GRANT: begin
               if (rule_a || rule_b) begin
                  ptr_d  = next_ptr;
                  hold_d = '0;
                  if (pick_valid) begin
                     grant_d = pick_grant;
                     gidx_d  = pick_idx;
                     state_d = HANDOVER;
                  end else begin
                     grant_d = '0;
                     gidx_d  = '0;
                     state_d = IDLE;
                  end
               end
            end
            HANDOVER: state_d = GRANT;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Outputs.
   always_comb begin
      m_hgrant = (state_q == GRANT) ? grant_q : '0;
      Haddr    = (state_q == GRANT) ? g_haddr : '0;
      Hwrite   = (state_q == GRANT) ? g_hwrite : 1'b0;
      Htrans   = bus_htrans;
      Hreadyin = accept;
      m_hready = '1;
      Hwdata   = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (down_q && (didx_q == IDX_W'(i))) begin
            m_hready[i] = Hreadyout;
            Hwdata      = m_hwdata[i*DATA_W +: DATA_W];
         end
      end
      m_hrdata = Hrdata;
      m_hresp  = Hresp;
   end

endmodule

// File: doc/ahb_bridge_arbiter.md
Name: ahb_bridge_arbiter

Overview:
Round-robin AHB-lite arbiter that shares the single AHB slave port of Bridge_Top among NUM_MST requesting masters. It tracks which master owns the address phase and which owns the data phase, and muxes address, control and write data to the bridge. It routes Hreadyout and Hrdata back to the owning master. The bridge qualifies transfers only with Hwrite/Hreadyin, so the arbiter gates Hreadyin so that only real NONSEQ/SEQ transfers reach it.

Parameters:
NUM_MST, 3, number of requesting masters (2..8)
MAX_HOLD, 4, max consecutive accepted transfers per grant before forced rotation when others request
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous active-low reset
m_req  in  NUM_MST  per-master bus request
m_haddr  in  NUM_MST*ADDR_W  per-master Haddr, master i at [i*ADDR_W +: ADDR_W]
m_htrans  in  NUM_MST*2  per-master Htrans (00 IDLE, 10 NONSEQ, 11 SEQ)
m_hwrite  in  NUM_MST  per-master Hwrite
m_hwdata  in  NUM_MST*DATA_W  per-master Hwdata
m_hlock  in  NUM_MST  lock request (used only with AHB_ARB_LOCK_EN)
m_hgrant  out  NUM_MST  one-hot address-phase grant
m_hready  out  NUM_MST  Hreadyout to the data-phase owner; 1 to all idle masters
m_hrdata  out  DATA_W  bridge Hrdata, broadcast
m_hresp  out  2  bridge Hresp, broadcast
Haddr  out  ADDR_W  to bridge
Htrans  out  2  to bridge
Hwrite  out  1  to bridge
Hwdata  out  DATA_W  to bridge, from the data-phase owner
Hreadyin  out  1  to bridge
Hreadyout  in  1  from bridge
Hrdata  in  DATA_W  from bridge
Hresp  in  2  from bridge

Behaviour:
- Reset (rst=0, async): m_hgrant=0, addr owner none, data owner none, rr pointer=0, hold count=0; Haddr=0, Htrans=00, Hwrite=0, Hwdata=0, Hreadyin=0.
- FSM (grant state) has three states:
  - IDLE: no grant. If any m_req is set, grant goes to the first requester at or after rr pointer, registered; m_hgrant is visible next cycle → state GRANT.
  - GRANT: the granted master's Haddr/Htrans/Hwrite pass combinationally to the bridge.
  - Hreadyin = Hreadyout & Htrans[1] & grant valid.
- Accepted transfer = Hreadyin=1 at posedge. On it, data owner <= addr owner and hold count increments.
- Hwdata and m_hready are selected by the data owner. The data owner clears on a cycle with Hreadyout=1 and no accepted transfer.
- Re-arbitration happens only at a posedge with Hreadyout=1, triggered by either:
  - (a) granted master's m_req=0 with Htrans=IDLE, or
  - (b) hold count=MAX_HOLD and any other m_req set.
- On re-arbitration: rr pointer <= granted index+1 (mod NUM_MST), hold count <= 0, new grant is registered, and a one-cycle handover drives Htrans=IDLE.
- If no other master requests, state → IDLE.
- A SEQ transfer must not be split by rotation. Rule (b) waits until the granted master presents IDLE or NONSEQ.
- Simultaneous requests are resolved by the rr pointer. Requests arriving during a transfer wait.
- Hreadyout=0 freezes grant, owners and counters.
- Hresp ERROR (01) is passed through; grant is unaffected.
- Reset mid-transfer drops everything immediately. Masters must restart.

Optional Feature:
AHB_ARB_LOCK_EN:
- Defined: while the granted master holds m_hlock=1, rule (b) is suppressed, so the hold count is ignored and the grant is kept until the lock drops and rule (a) fires.
- Undefined: m_hlock is ignored and left unconnected internally.

Decomposition:
- Package ahb_arb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ constants, HRESP_OKAY/ERROR, arb_state_e enum {IDLE, GRANT, HANDOVER}, function rr_pick(req, ptr) returning the one-hot winner.
- Sub-module rr_picker: combinational rotate-priority-encoder. Top holds the FSM, counters and muxes.

Test Plan:
1. Single master 0 issues NONSEQ write Haddr=32'h8000_0010, Hwdata=32'hA5A5_0001 → m_hgrant=001 one cycle later; Hreadyin=1 only in the address cycle; bridge Pselx=001 with Pwdata=32'hA5A5_0001.
2. Masters 0,1,2 request simultaneously from reset → grants 001, 010, 100 in order, each after its master goes IDLE. The rr pointer wraps to 0.
3. Master 1 issues 6 back-to-back reads while master 2 requests, MAX_HOLD=4 → exactly 4 transfers accepted, then handover cycle with Htrans=00, then m_hgrant=100.
4. Hreadyout held 0 for 3 cycles mid-write → Haddr, m_hgrant and Hwdata stable; m_hready of owner=0; other masters' m_hready=1.
5. rst asserted during a data phase → all outputs reach their reset values without waiting for a clock edge. After release, master 0 requesting alone gets the grant.
6. AHB_ARB_LOCK_EN with master 0 locked for 8 transfers while master 1 requests → no rotation until the lock drops, then grant=010.
